bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-add-3), one input bit per clock.
- Inverse of the BCD-to-binary path already in the design. Produces packed BCD digits from an unsigned binary word for display and decimal-output stages.
- Uses a start/busy/done handshake so a single small datapath handles wide operands without a giant combinational chain.

Parameters:
- BIN_W, 32, width of the unsigned binary input.
- DIGITS, 10, number of BCD output digits. Must satisfy DIGITS >= ceil(BIN_W*log10(2)); violation is an elaboration-time error.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only when busy=0.
- bin  input  BIN_W  unsigned operand; captured on the accepted-start edge only.
- busy  output  1  high while a conversion is in flight.
- done  output  1  one-cycle pulse when bcd/sig_digits update.
- bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
- sig_digits  output  clog2(DIGITS+1)  count of significant digits (no leading zeros); 1 for value 0.

Behaviour:
- Reset (reset_n low, async): state=IDLE, busy=0, done=0, bcd=0, sig_digits=0, internal shift/scratch/counter cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, capture bin into shift reg, clear scratch digits, counter=BIN_W, go to SHIFT, busy=1 from the next cycle.
- SHIFT, each cycle, in this order:
  - every scratch digit >=5 gets +3 (4-bit add, no carry between digits);
  - {scratch, shift} shifted left 1, shift-reg MSB enters scratch LSB;
  - counter decrements.
- SHIFT exit: after exactly BIN_W shift cycles, go to DONE.
- DONE: bcd<=scratch, sig_digits<=index of highest nonzero digit+1 (1 if all zero), done=1 for this cycle only, busy=0. Next state is IDLE, or SHIFT if start=1 in this cycle (back-to-back accepted).
- Latency: start accepted at edge k; done and new bcd visible after edge k+BIN_W+1. busy high from edge k+1 through edge k+BIN_W.
- start while busy=1: ignored; bin not sampled; the in-flight conversion is unaffected.
- bin changes after capture: no effect on the in-flight conversion.
- bcd/sig_digits hold the last result until the next DONE; they are never partially updated.
- Reset mid-conversion: immediate return to reset values; no done pulse; the partial result is discarded.
- Digit values never exceed 9. bin max (2^BIN_W-1) must convert without overflow given the DIGITS constraint.

Test Plan:
- Reset, then start with bin=0 -> done exactly 33 cycles after the start edge; bcd=0x0000000000, sig_digits=1; busy high 32 cycles.
- bin=255 -> bcd=0x0000000255, sig_digits=3. bin=1000000 -> bcd=0x0001000000, sig_digits=7.
- bin=32'hFFFFFFFF -> bcd=0x4294967295, sig_digits=10; no digit >9 at any cycle (assertion on scratch).
- Back-to-back: start held high with bin=12 then bin=34 presented in the DONE cycle -> done pulses 33 cycles apart; bcd=0x12 then 0x34; busy low for exactly one cycle between them.
- start pulsed with bin=99 at cycle 10 of a running bin=7 conversion -> result 0x07, no second done, 99 never appears.
- reset_n asserted at cycle 15 of a bin=123456 conversion -> all outputs 0 immediately, no done. A new start with bin=42 after release -> bcd=0x42, sig_digits=2.

Source files
------------

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - start/busy/done handshake and result bus for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) ();
  localparam int SIG_W = $clog2(DIGITS + 1);

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [SIG_W-1:0]      sig_digits;

  modport master (
    output start, bin,
    input  busy, done, bcd, sig_digits
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, sig_digits
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one bit per clock
module bin_to_bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int SIG_W = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);

  // 30103/100000 slightly over-estimates log10(2), so this never accepts too few digits
  if (DIGITS * 100000 < BIN_W * 30103) begin : g_digits_too_small
    $error("bin_to_bcd_seq: DIGITS too small to hold 2**BIN_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [BIN_W-1:0]     shift_q;
  logic [4*DIGITS-1:0]  scratch_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [SIG_W-1:0]     sig_q;

  logic [4*DIGITS-1:0]  adj_d;
  logic [4*DIGITS-1:0]  scratch_d;
  logic [BIN_W-1:0]     shift_d;
  logic [SIG_W-1:0]     sig_d;

  // Add-3 correction per digit happens before the shift, with no carry between nibbles
  always_comb begin
    logic [3:0] dig;
    adj_d = scratch_q;
    dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = scratch_q[4*i +: 4];
      adj_d[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    scratch_d = {adj_d[4*DIGITS-2:0], shift_q[BIN_W-1]};
    shift_d   = shift_q << 1;
  end

  always_comb begin
    sig_d = SIG_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] != 4'd0) begin
        sig_d = SIG_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      sig_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q - CNT_W'(1);
          busy_q    <= 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q  <= scratch_q;
          sig_q  <= sig_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          // A start here is accepted immediately so back-to-back conversions lose no cycle
          if (bus.start) begin
            shift_q   <= bus.bin;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(BIN_W);
            state_q   <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bcd        = bcd_q;
  assign bus.sig_digits = sig_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
    a_digit_le9 : assert property (@(posedge clk) disable iff (!reset_n)
      scratch_q[4*g +: 4] <= 4'd9);
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - randomized scoreboard bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
  localparam int BIN_W  = 32;
  localparam int DIGITS = 10;
  localparam int LAT    = BIN_W + 1;

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    int                  sig;
    int                  due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Decimal digits by repeated division: the plain-arithmetic meaning of the result
  function automatic exp_t ref_conv(input longint unsigned v);
    exp_t            e;
    longint unsigned t;
    e.bcd = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.sig = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      e.sig++;
    end
    e.due = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got bcd %0h expected no done (cycle %0d)", bus.bcd, cycle);
        end else begin
          e = q.pop_front();
          chk("bcd", 64'(bus.bcd), 64'(e.bcd));
          chk("sig_digits", 64'(bus.sig_digits), 64'(e.sig));
          chk("done_latency", 64'(cycle), 64'(e.due));
          chk("busy_cycles", 64'(busy_run), 64'(BIN_W));
        end
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns one negedge after acceptance; acc is the accepting edge number
  task automatic issue(input logic [BIN_W-1:0] v, output int acc);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.bin   = v;
    @(negedge clk);
    acc   = cycle;
    e     = ref_conv(longint'(v));
    e.due = acc + LAT;
    q.push_back(e);
    bus.start = 1'b0;
    bus.bin   = $urandom;
    @(negedge clk);
  endtask

  initial begin
    int   acc;
    exp_t e;
    int   t;
    logic [BIN_W-1:0] v;

    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    wait_cycles(3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_bcd", 64'(bus.bcd), 64'd0);
    chk("rst_sig", 64'(bus.sig_digits), 64'd0);
    reset_n = 1'b1;
    wait_cycles(2);

    issue(32'd0, acc);
    issue(32'd255, acc);
    issue(32'd1000000, acc);
    issue(32'hFFFF_FFFF, acc);

    // Back-to-back: start held, second operand presented in the DONE-state cycle
    wait_idle();
    bus.start = 1'b1;
    bus.bin   = 32'd12;
    @(negedge clk);
    acc   = cycle;
    e     = ref_conv(64'd12);
    e.due = acc + LAT;
    q.push_back(e);
    while (cycle < acc + BIN_W) @(negedge clk);
    bus.bin = 32'd34;
    e       = ref_conv(64'd34);
    e.due   = acc + 2 * LAT;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = $urandom;
    @(negedge clk);

    // Start pulse mid-conversion must be ignored
    issue(32'd7, acc);
    while (cycle < acc + 9) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 32'd99;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    wait_cycles(40);

    // Reset mid-conversion discards the partial result
    issue(32'd123456, acc);
    while (cycle < acc + 14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_bcd", 64'(bus.bcd), 64'd0);
    chk("midrst_sig", 64'(bus.sig_digits), 64'd0);
    q.delete();
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);
    issue(32'd42, acc);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       v = BIN_W'($urandom_range(0, 99));
        1:       v = BIN_W'($urandom_range(0, 999999));
        default: v = $urandom;
      endcase
      issue(v, acc);
      if ($urandom_range(0, 1) == 1) begin
        while (cycle < acc + int'($urandom_range(2, 30))) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_cycles($urandom_range(0, 3));
    end

    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    wait_cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
